// File: rtl/timer_core_param.sv
// Two-mode (stopwatch / countdown) timer core with IDLE/RUN/PAUSE/DONE control, Clear and runtime preset.
// Define LAP_CAPTURE_EN to enable the LapCap-driven lap registers; otherwise LapLSB/LapMSB read 0.
module timer_core_param #(
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned SEC_W     = 8,
  parameter int unsigned SEC_MAX   = 199,
  parameter int unsigned CD_PRESET = 120
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StartStop,
  input  logic             ModeSel,
  input  logic             Clear,
  input  logic             PresetLoad,
  input  logic [SEC_W-1:0] PresetSec,
  input  logic             LapCap,
  output logic [7:0]       LSBbinaryout,
  output logic [SEC_W-1:0] MSBbinaryout,
  output logic             Running,
  output logic             Expired,
  output logic [7:0]       LapLSB,
  output logic [SEC_W-1:0] LapMSB
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state_q;
  logic [7:0]       lsb_q;
  logic [SEC_W-1:0] msb_q;
  logic [SEC_W-1:0] preset_q;
  logic [PW-1:0]    pre_q;
  logic             ss_q;
  logic             mode_q;
  logic             run_q;
  logic             exp_q;

  logic             ss_edge;
  logic             tick;
  logic             sw_at_max;
  logic             cd_at_zero;
  logic             cd_hits_zero;
  logic             terminal;
  logic             expire_now;
  logic [SEC_W-1:0] preset_clamped;
  logic [7:0]       up_lsb, dn_lsb;
  logic [SEC_W-1:0] up_msb, dn_msb;

  assign ss_edge      = StartStop & ~ss_q;
  assign tick         = (pre_q == PW'(TICK_DIV - 1));
  assign sw_at_max    = (msb_q == SEC_W'(SEC_MAX)) && (lsb_q == 8'd99);
  assign cd_at_zero   = (msb_q == '0) && (lsb_q == '0);
  assign cd_hits_zero = (msb_q == '0) && (lsb_q == 8'd1);
  assign terminal     = mode_q ? cd_at_zero : sw_at_max;

  // Countdown already at 0.00 expires without waiting for a tick; otherwise expiry rides the tick.
  assign expire_now = (mode_q && cd_at_zero) ||
                      (tick && (mode_q ? cd_hits_zero : sw_at_max));

  assign preset_clamped = (PresetSec > SEC_W'(SEC_MAX)) ? SEC_W'(SEC_MAX) : PresetSec;

  assign up_lsb = (lsb_q == 8'd99) ? '0 : lsb_q + 8'd1;
  assign up_msb = (lsb_q == 8'd99) ? msb_q + SEC_W'(1) : msb_q;
  assign dn_lsb = (lsb_q == '0) ? 8'd99 : lsb_q - 8'd1;
  assign dn_msb = (lsb_q == '0) ? msb_q - SEC_W'(1) : msb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lsb_q    <= '0;
      msb_q    <= '0;
      pre_q    <= '0;
      preset_q <= SEC_W'(CD_PRESET);
      ss_q     <= 1'b0;
      mode_q   <= 1'b0;
      run_q    <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      ss_q <= StartStop;
      if (Clear) begin
        state_q <= IDLE;
        lsb_q   <= '0;
        msb_q   <= ModeSel ? preset_q : '0;
        pre_q   <= '0;
        mode_q  <= ModeSel;
        run_q   <= 1'b0;
        exp_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            lsb_q  <= '0;
            msb_q  <= ModeSel ? preset_q : '0;
            pre_q  <= '0;
            mode_q <= ModeSel;
            if (PresetLoad) preset_q <= preset_clamped;
            if (ss_edge) begin
              state_q <= RUN;
              run_q   <= 1'b1;
            end
          end
          RUN: begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
            if (tick && !terminal) begin
              lsb_q <= mode_q ? dn_lsb : up_lsb;
              msb_q <= mode_q ? dn_msb : up_msb;
            end
            // A tick coinciding with a pause edge still lands before the state change.
            if (expire_now) begin
              state_q <= DONE;
              run_q   <= 1'b0;
              exp_q   <= 1'b1;
            end else if (ss_edge) begin
              state_q <= PAUSE;
              run_q   <= 1'b0;
            end
          end
          PAUSE: begin
            if (ss_edge) begin
              state_q <= RUN;
              run_q   <= 1'b1;
            end
          end
          DONE: begin
            state_q <= DONE;
          end
          default: begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            exp_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign LSBbinaryout = lsb_q;
  assign MSBbinaryout = msb_q;
  assign Running      = run_q;
  assign Expired      = exp_q;

`ifdef LAP_CAPTURE_EN
  logic             lap_prev_q;
  logic [7:0]       lap_lsb_q;
  logic [SEC_W-1:0] lap_msb_q;

  // Lap registers survive Clear on purpose; only reset or a new capture changes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_prev_q <= 1'b0;
      lap_lsb_q  <= '0;
      lap_msb_q  <= '0;
    end else begin
      lap_prev_q <= LapCap;
      if (LapCap && !lap_prev_q && (state_q == RUN || state_q == PAUSE)) begin
        lap_lsb_q <= lsb_q;
        lap_msb_q <= msb_q;
      end
    end
  end

  assign LapLSB = lap_lsb_q;
  assign LapMSB = lap_msb_q;
`else
  logic unused_lapcap;
  assign unused_lapcap = LapCap;
  assign LapLSB        = '0;
  assign LapMSB        = '0;
`endif

endmodule

// File: tb/tb_timer_core_param.sv
// Scoreboard bench for timer_core_param: three instances (default, TICK_DIV=4, SEC_MAX=1) on shared inputs.
module tb_timer_core_param;

`ifdef LAP_CAPTURE_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] lsb;
    logic [7:0] msb;
    logic       run;
    logic       expd;
    logic [7:0] lap_lsb;
    logic [7:0] lap_msb;
  } obs_t;

  typedef struct packed {
    logic [15:0] cyc;
    logic [1:0]  sel;
    obs_t        v;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       StartStop, ModeSel, Clear, PresetLoad, LapCap;
  logic [7:0] PresetSec;

  logic [7:0] lsb0, msb0, llsb0, lmsb0, lsb1, msb1, llsb1, lmsb1, lsb2, msb2, llsb2, lmsb2;
  logic       run0, exp0, run1, exp1, run2, exp2;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  sb_t         sb[$];

  always #5 clk = ~clk;

  timer_core_param dut (
    .clk(clk), .rst_n(rst_n), .StartStop(StartStop), .ModeSel(ModeSel), .Clear(Clear),
    .PresetLoad(PresetLoad), .PresetSec(PresetSec), .LapCap(LapCap),
    .LSBbinaryout(lsb0), .MSBbinaryout(msb0), .Running(run0), .Expired(exp0),
    .LapLSB(llsb0), .LapMSB(lmsb0)
  );

  timer_core_param #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .StartStop(StartStop), .ModeSel(ModeSel), .Clear(Clear),
    .PresetLoad(PresetLoad), .PresetSec(PresetSec), .LapCap(LapCap),
    .LSBbinaryout(lsb1), .MSBbinaryout(msb1), .Running(run1), .Expired(exp1),
    .LapLSB(llsb1), .LapMSB(lmsb1)
  );

  timer_core_param #(.SEC_MAX(1), .CD_PRESET(1)) dutm (
    .clk(clk), .rst_n(rst_n), .StartStop(StartStop), .ModeSel(ModeSel), .Clear(Clear),
    .PresetLoad(PresetLoad), .PresetSec(PresetSec), .LapCap(LapCap),
    .LSBbinaryout(lsb2), .MSBbinaryout(msb2), .Running(run2), .Expired(exp2),
    .LapLSB(llsb2), .LapMSB(lmsb2)
  );

  function automatic obs_t observe(input logic [1:0] sel);
    obs_t o;
    case (sel)
      2'd1:    o = '{lsb: lsb1, msb: msb1, run: run1, expd: exp1, lap_lsb: llsb1, lap_msb: lmsb1};
      2'd2:    o = '{lsb: lsb2, msb: msb2, run: run2, expd: exp2, lap_lsb: llsb2, lap_msb: lmsb2};
      default: o = '{lsb: lsb0, msb: msb0, run: run0, expd: exp0, lap_lsb: llsb0, lap_msb: lmsb0};
    endcase
    return o;
  endfunction

  // Queue an expectation: at loop cycle c, instance s shows sec.hund, flags, and lap sec.hund.
  function automatic void push(input int unsigned c, input int unsigned s,
                               input int unsigned sec, input int unsigned hund,
                               input logic r, input logic x,
                               input int unsigned lsec, input int unsigned lhund);
    sb_t e;
    e.cyc       = 16'(c);
    e.sel       = 2'(s);
    e.v.lsb     = 8'(hund);
    e.v.msb     = 8'(sec);
    e.v.run     = r;
    e.v.expd    = x;
    e.v.lap_lsb = 8'(lhund);
    e.v.lap_msb = 8'(lsec);
    sb.push_back(e);
  endfunction

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst_n = 1'b0; StartStop = 1'b0; ModeSel = 1'b0; Clear = 1'b0;
    PresetLoad = 1'b0; PresetSec = '0; LapCap = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    sb.delete();
  endtask

  // Async reset mid-run: outputs drop before any clock edge; preset returns to CD_PRESET.
  task automatic test_reset();
    sb_t e; obs_t got;
    reset_all();
    StartStop = 1'b1; cyc(1); StartStop = 1'b0; cyc(5);
    ModeSel = 1'b1;
    rst_n   = 1'b0;
    #2;
    for (int s = 0; s < 3; s++) push(0, s, 0, 0, 0, 0, 0, 0);
    push(1, 0, 120, 0, 0, 0, 0, 0);
    push(1, 1, 120, 0, 0, 0, 0, 0);
    push(1, 2, 1, 0, 0, 0, 0, 0);
    for (int c = 0; c <= 1; c++) begin
      while (sb.size() > 0 && sb[0].cyc == 16'(c)) begin
        e = sb.pop_front(); got = observe(e.sel); vectors++;
        if (got !== e.v) begin
          miscompares++;
          $display("FAIL reset c=%0d dut%0d got=%h want=%h", c, e.sel, got, e.v);
        end
      end
      if (c == 0) rst_n = 1'b1;
      if (c < 1) cyc(1);
    end
  endtask

  // Stopwatch at TICK_DIV=1; pause edge coincides with a tick, so the pause shows 2.51.
  task automatic test_stopwatch();
    sb_t e; obs_t got;
    reset_all();
    StartStop = 1'b1; cyc(1);
    push(0, 0, 0, 0, 1, 0, 0, 0);
    push(1, 0, 0, 1, 1, 0, 0, 0);
    push(99, 0, 0, 99, 1, 0, 0, 0);
    push(100, 0, 1, 0, 1, 0, 0, 0);
    push(250, 0, 2, 50, 1, 0, 0, 0);
    push(251, 0, 2, 51, 0, 0, 0, 0);
    push(351, 0, 2, 51, 0, 0, 0, 0);
    for (int c = 0; c <= 351; c++) begin
      while (sb.size() > 0 && sb[0].cyc == 16'(c)) begin
        e = sb.pop_front(); got = observe(e.sel); vectors++;
        if (got !== e.v) begin
          miscompares++;
          $display("FAIL stopwatch c=%0d dut%0d got=%h want=%h", c, e.sel, got, e.v);
        end
      end
      if (c == 0)   StartStop = 1'b0;
      if (c == 250) StartStop = 1'b1;
      if (c == 251) StartStop = 1'b0;
      if (c < 351) cyc(1);
    end
  endtask

  // Held StartStop gives one start; ModeSel ignored while running; Clear beats a same-cycle edge.
  task automatic test_hold_and_clear();
    sb_t e; obs_t got;
    reset_all();
    StartStop = 1'b1; cyc(1);
    push(0, 0, 0, 0, 1, 0, 0, 0);
    push(20, 0, 0, 20, 1, 0, 0, 0);
    push(150, 0, 1, 50, 1, 0, 0, 0);
    push(151, 0, 120, 0, 0, 0, 0, 0);
    push(152, 0, 120, 0, 0, 0, 0, 0);
    push(153, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c <= 153; c++) begin
      while (sb.size() > 0 && sb[0].cyc == 16'(c)) begin
        e = sb.pop_front(); got = observe(e.sel); vectors++;
        if (got !== e.v) begin
          miscompares++;
          $display("FAIL hold_clear c=%0d dut%0d got=%h want=%h", c, e.sel, got, e.v);
        end
      end
      if (c == 10)  ModeSel = 1'b1;
      if (c == 19)  StartStop = 1'b0;
      if (c == 150) begin Clear = 1'b1; StartStop = 1'b1; end
      if (c == 151) Clear = 1'b0;
      if (c == 152) begin StartStop = 1'b0; ModeSel = 1'b0; end
      if (c < 153) cyc(1);
    end
  endtask

  // Countdown from a loaded preset of 2 s to expiry, then preset 0 which expires after one RUN clk.
  task automatic test_countdown();
    sb_t e; obs_t got;
    reset_all();
    ModeSel = 1'b1; PresetLoad = 1'b1; PresetSec = 8'd2;
    cyc(1);
    PresetLoad = 1'b0;
    cyc(1);
    push(0, 0, 2, 0, 0, 0, 0, 0);
    push(1, 0, 2, 0, 1, 0, 0, 0);
    push(2, 0, 1, 99, 1, 0, 0, 0);
    push(200, 0, 0, 1, 1, 0, 0, 0);
    push(201, 0, 0, 0, 0, 1, 0, 0);
    push(210, 0, 0, 0, 0, 1, 0, 0);
    push(211, 0, 2, 0, 0, 0, 0, 0);
    push(213, 0, 0, 0, 0, 0, 0, 0);
    push(214, 0, 0, 0, 1, 0, 0, 0);
    push(215, 0, 0, 0, 0, 1, 0, 0);
    for (int c = 0; c <= 215; c++) begin
      while (sb.size() > 0 && sb[0].cyc == 16'(c)) begin
        e = sb.pop_front(); got = observe(e.sel); vectors++;
        if (got !== e.v) begin
          miscompares++;
          $display("FAIL countdown c=%0d dut%0d got=%h want=%h", c, e.sel, got, e.v);
        end
      end
      case (c)
        0:   StartStop = 1'b1;
        1:   StartStop = 1'b0;
        100: begin PresetLoad = 1'b1; PresetSec = 8'd50; end
        101: PresetLoad = 1'b0;
        205: StartStop = 1'b1;
        206: StartStop = 1'b0;
        210: Clear = 1'b1;
        211: begin Clear = 1'b0; PresetLoad = 1'b1; PresetSec = 8'd0; end
        212: PresetLoad = 1'b0;
        213: StartStop = 1'b1;
        214: StartStop = 1'b0;
        default: ;
      endcase
      if (c < 215) cyc(1);
    end
  endtask

  // TICK_DIV=4 latency, then pause/resume keeps prescaler phase (next tick one clk after resume).
  task automatic test_prescaler();
    sb_t e; obs_t got;
    reset_all();
    StartStop = 1'b1; cyc(1);
    push(0, 1, 0, 0, 1, 0, 0, 0);
    push(3, 1, 0, 0, 1, 0, 0, 0);
    push(4, 1, 0, 1, 1, 0, 0, 0);
    push(400, 1, 1, 0, 1, 0, 0, 0);
    push(410, 1, 1, 0, 0, 0, 0, 0);
    push(421, 1, 1, 0, 1, 0, 0, 0);
    push(422, 1, 1, 1, 1, 0, 0, 0);
    for (int c = 0; c <= 422; c++) begin
      while (sb.size() > 0 && sb[0].cyc == 16'(c)) begin
        e = sb.pop_front(); got = observe(e.sel); vectors++;
        if (got !== e.v) begin
          miscompares++;
          $display("FAIL prescaler c=%0d dut%0d got=%h want=%h", c, e.sel, got, e.v);
        end
      end
      if (c == 0)   StartStop = 1'b0;
      if (c == 402) StartStop = 1'b1;
      if (c == 403) StartStop = 1'b0;
      if (c == 420) StartStop = 1'b1;
      if (c == 421) StartStop = 1'b0;
      if (c < 422) cyc(1);
    end
  endtask

  // SEC_MAX=1 saturates at 1.99; oversize preset clamps to SEC_MAX on both instances.
  task automatic test_saturate_clamp();
    sb_t e; obs_t got;
    reset_all();
    StartStop = 1'b1; cyc(1);
    push(0, 2, 0, 0, 1, 0, 0, 0);
    push(199, 2, 1, 99, 1, 0, 0, 0);
    push(200, 2, 1, 99, 0, 1, 0, 0);
    push(300, 2, 1, 99, 0, 1, 0, 0);
    push(301, 2, 1, 0, 0, 0, 0, 0);
    push(303, 0, 199, 0, 0, 0, 0, 0);
    push(303, 2, 1, 0, 0, 0, 0, 0);
    for (int c = 0; c <= 303; c++) begin
      while (sb.size() > 0 && sb[0].cyc == 16'(c)) begin
        e = sb.pop_front(); got = observe(e.sel); vectors++;
        if (got !== e.v) begin
          miscompares++;
          $display("FAIL saturate c=%0d dut%0d got=%h want=%h", c, e.sel, got, e.v);
        end
      end
      if (c == 0)   StartStop = 1'b0;
      if (c == 300) begin Clear = 1'b1; ModeSel = 1'b1; end
      if (c == 301) begin Clear = 1'b0; PresetLoad = 1'b1; PresetSec = 8'd255; end
      if (c == 302) PresetLoad = 1'b0;
      if (c < 303) cyc(1);
    end
  endtask

  // Lap capture at 0.37 (zero when the feature is compiled out), then async reset mid-run.
  task automatic test_lap();
    sb_t e; obs_t got;
    reset_all();
    PresetLoad = 1'b1; PresetSec = 8'd50;
    cyc(1);
    PresetLoad = 1'b0; StartStop = 1'b1;
    cyc(1);
    push(37, 0, 0, 37, 1, 0, 0, 0);
    push(38, 0, 0, 38, 1, 0, 0, LAP ? 37 : 0);
    push(60, 0, 0, 60, 1, 0, 0, LAP ? 37 : 0);
    push(61, 0, 0, 0, 0, 0, 0, 0);
    push(62, 0, 120, 0, 0, 0, 0, 0);
    for (int c = 0; c <= 62; c++) begin
      while (sb.size() > 0 && sb[0].cyc == 16'(c)) begin
        e = sb.pop_front(); got = observe(e.sel); vectors++;
        if (got !== e.v) begin
          miscompares++;
          $display("FAIL lap c=%0d dut%0d got=%h want=%h", c, e.sel, got, e.v);
        end
      end
      if (c == 0)  StartStop = 1'b0;
      if (c == 37) LapCap = 1'b1;
      if (c == 45) LapCap = 1'b0;
      if (c == 60) begin rst_n = 1'b0; ModeSel = 1'b1; end
      if (c == 61) rst_n = 1'b1;
      if (c < 62) cyc(1);
    end
  endtask

  initial begin
    rst_n = 1'b0; StartStop = 1'b0; ModeSel = 1'b0; Clear = 1'b0;
    PresetLoad = 1'b0; PresetSec = '0; LapCap = 1'b0;
    test_reset();
    test_stopwatch();
    test_hold_and_clear();
    test_countdown();
    test_prescaler();
    test_saturate_clamp();
    test_lap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
